mem_traffic_checker: RTL and testbench
======================================

# mem_traffic_checker

Self-checking memory traffic source that drives the CPU-side request port of the DDR2 memory wrapper (`mem_example`) on the `clk_cpu` domain. It generates pseudo-random address/data pairs, performs a write followed by a read-back of the same address, compares the returned data, and keeps pass and error statistics for board-level bring-up via LEDs or a debug core. It replaces the inline traffic generator in the top level and sits directly upstream of the memory wrapper.

## Interface
Parameters:
- `LFSR_SEED`, 32'h0: LFSR reset value. XNOR feedback, so all-zeros is legal and all-ones is the lock-up state.
- `ADDR_MASK`, 28'hFFFFFFF: ANDed onto the generated address.
- `TIMEOUT_CYC`, 4096: maximum cycles spent waiting in WWAIT/RWAIT before a timeout is declared.

Ports (one clock; reset is asynchronous and active-low):
- `clk_cpu`, in, 1: traffic clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run test iterations while high.
- `clear`, in, 1: synchronous clear of counters and sticky flags.
- `mem_ready`, in, 1: wrapper can accept a request.
- `mem_transaction_complete`, in, 1: single-cycle completion pulse.
- `mem_d_from_ram`, in, 64: read data.
- `mem_addr`, out, 28: request address.
- `mem_d_to_ram`, out, 64: write data.
- `mem_transaction_width`, out, 2: width code.
- `mem_wstrobe` / `mem_rstrobe`, out, 1 each: single-cycle request pulses.
- `dequ`, out, 1: result of the last compare.
- `err_flag`, out, 1: sticky, set on any miscompare.
- `timeout`, out, 1: sticky, set on a completion timeout.
- `pass_cnt`, out, 32: passing iterations, wraps.
- `err_cnt`, out, 16: failing iterations, saturates at 16'hFFFF.
- `first_err_addr`, out, 28: address of the first miscompare since reset or clear.
- `busy`, out, 1: high in every state except IDLE and HALT.

## Operation
- Reset values: all outputs 0; the state is IDLE; the LFSR loads `LFSR_SEED`.
- LFSR update is `x <= {x[30:0], ~^{x[31],x[21],x[1],x[0]}}`. It advances only in GEN, once per iteration.
- **IDLE**: go to GEN when `enable` is high.
- **GEN** (1 cycle):
  - `mem_addr <= x[27:0] & ADDR_MASK`.
  - `mem_d_to_ram <= {~x, x}`.
  - Advance the LFSR, then go to WRITE.
- **WRITE**: when `mem_ready` is high, set `mem_wstrobe`, set width to 64-bit, go to WWAIT.
- **WWAIT**:
  - Clear `mem_wstrobe` on entry, so the strobe is exactly 1 cycle wide.
  - On `mem_transaction_complete`, go to READ.
- **READ**: when `mem_ready` is high, set `mem_rstrobe`, set the read width (see Configuration), go to RWAIT.
- **RWAIT**: clear `mem_rstrobe` on entry. On `mem_transaction_complete`:
  - Register `dequ` from the compare.
  - On a match, increment `pass_cnt`.
  - On a miscompare:
    - set `err_flag`;
    - increment `err_cnt` (saturating);
    - load `first_err_addr` only if `err_cnt` is 0.
  - Next state is GEN if `enable` is high, otherwise IDLE.
- **HALT**: entered from WWAIT or RWAIT after `TIMEOUT_CYC` cycles without a completion; sets `timeout`. The only exits are `clear` (to IDLE) or reset.
- Width codes: 2'd0 = 8-bit, 2'd1 = 16-bit, 2'd2 = 32-bit, 2'd3 = 64-bit.

## Timing
- After `enable` rises in IDLE:
  - GEN occurs in the next cycle.
  - With `mem_ready` held high, `mem_wstrobe` is high 3 cycles after the `enable` edge.
- The timeout counter resets on entry to WWAIT and to RWAIT, and counts every cycle spent in those states.
- If completion and timeout expiry coincide in the same cycle, completion wins.
- Deasserting `enable` mid-iteration: the iteration finishes, then the block goes to IDLE. No request is ever abandoned.
- `clear` zeroes `pass_cnt`, `err_cnt`, `first_err_addr`, `err_flag`, `timeout` and `dequ`.
  - If `clear` coincides with an RWAIT completion, `clear` wins and the counters read 0 afterwards. The state still advances normally.
  - `clear` does not reset the LFSR.
- Completion pulses outside WWAIT/RWAIT are ignored.
- An asynchronous reset mid-transaction immediately drops both strobes to 0.

## Configuration
- `MEMTEST_FULL_COMPARE_EN` defined:
  - the read uses width 2'd3;
  - all 64 bits of `mem_d_from_ram` are compared with `mem_d_to_ram`.
- Undefined:
  - the read uses width 2'd1;
  - only bits [63:48] are compared.

## Structure
- Shared package `mem_pkg` holds:
  - the width codes (`RAM_WIDTH8/16/32/64`);
  - the state encodings: IDLE, GEN, WRITE, WWAIT, READ, RWAIT, HALT.
- The memory wrapper uses the same width constants.
- One sub-module, `lfsr32`, with seed parameter, `advance` input and 32-bit `q` output.

## Test plan
- **Seed and data pattern.** Seed 0, memory model always ready, completion 5 cycles after each strobe, `enable` = 1:
  - first write has addr 28'h0000000 and data 64'hFFFFFFFF_00000000;
  - second write has addr 28'h0000001 and data 64'hFFFFFFFE_00000001.
- **Clean run.** Same setup for 100 iterations with no corruption → `pass_cnt` = 100, `err_cnt` = 0, `err_flag` = 0, `dequ` = 1.
- **Single corruption.** Model flips bit 50 on the read of iteration 3 → `dequ` = 0 after that read, `err_cnt` = 1, `err_flag` = 1, `first_err_addr` = that iteration's address. The next iteration passes and `err_flag` stays 1.
- **Timeout.** `TIMEOUT_CYC` = 16 and the model never completes the write → `timeout` = 1 after 16 cycles in WWAIT, `busy` = 0, state HALT. A `clear` pulse then returns the block to IDLE.
- **Enable drop and reset.** `enable` dropped during WWAIT → the read still issues, `pass_cnt` increments once more, then IDLE. `rst_n` asserted while `mem_rstrobe` is high → strobe and all outputs are 0 in the same cycle.
- **Bits outside the compare.** Without `MEMTEST_FULL_COMPARE_EN`, a corruption of bit 3 → no error; with the macro defined, the same corruption → `err_cnt` = 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-interface constants: transaction width codes, traffic-checker
// state encodings and the LFSR step used to generate test patterns.
package mem_pkg;

    localparam logic [1:0] RAM_WIDTH8  = 2'd0;
    localparam logic [1:0] RAM_WIDTH16 = 2'd1;
    localparam logic [1:0] RAM_WIDTH32 = 2'd2;
    localparam logic [1:0] RAM_WIDTH64 = 2'd3;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GEN   = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] WWAIT = 3'd3;
    localparam logic [2:0] READ  = 3'd4;
    localparam logic [2:0] RWAIT = 3'd5;
    localparam logic [2:0] HALT  = 3'd6;

    // XNOR feedback: all-zeros is a legal state, all-ones locks up.
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {x[30:0], ~^{x[31], x[21], x[1], x[0]}};
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit XNOR-feedback LFSR that steps once per cycle while advance is high.
module lfsr32
    import mem_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0
) (
    input  logic        clk_cpu,
    input  logic        rst_n,
    input  logic        advance,
    output logic [31:0] q
);

    logic [31:0] q_reg;

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= SEED;
        end else if (advance) begin
            q_reg <= lfsr_next(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mem_traffic_checker.sv
// Write/read-back traffic source for the DDR2 wrapper CPU port with pass/error stats.
// Optional macro MEMTEST_FULL_COMPARE_EN: 64-bit read-back and full-width compare.
module mem_traffic_checker
    import mem_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED   = 32'h0,
    parameter logic [27:0] ADDR_MASK   = 28'hFFFFFFF,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk_cpu,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear,
    input  logic        mem_ready,
    input  logic        mem_transaction_complete,
    input  logic [63:0] mem_d_from_ram,
    output logic [27:0] mem_addr,
    output logic [63:0] mem_d_to_ram,
    output logic [1:0]  mem_transaction_width,
    output logic        mem_wstrobe,
    output logic        mem_rstrobe,
    output logic        dequ,
    output logic        err_flag,
    output logic        timeout,
    output logic [31:0] pass_cnt,
    output logic [15:0] err_cnt,
    output logic [27:0] first_err_addr,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef MEMTEST_FULL_COMPARE_EN
    localparam logic [1:0]  READ_WIDTH = RAM_WIDTH64;
    localparam logic [63:0] CMP_MASK   = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    localparam logic [1:0]  READ_WIDTH = RAM_WIDTH16;
    localparam logic [63:0] CMP_MASK   = 64'hFFFF_0000_0000_0000;
`endif

    logic [2:0]    state_reg;
    logic [TW-1:0] tcnt_reg;
    logic [27:0]   addr_reg;
    logic [63:0]   d_to_ram_reg;
    logic [1:0]    width_reg;
    logic          wstrobe_reg;
    logic          rstrobe_reg;
    logic          dequ_reg;
    logic          err_flag_reg;
    logic          timeout_reg;
    logic [31:0]   pass_cnt_reg;
    logic [15:0]   err_cnt_reg;
    logic [27:0]   first_err_addr_reg;
    logic [31:0]   lfsr_q;
    logic          data_match;

    lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_cpu (clk_cpu),
        .rst_n   (rst_n),
        .advance (state_reg == GEN),
        .q       (lfsr_q)
    );

    assign data_match = ((mem_d_from_ram ^ d_to_ram_reg) & CMP_MASK) == 64'd0;

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            tcnt_reg           <= '0;
            addr_reg           <= '0;
            d_to_ram_reg       <= '0;
            width_reg          <= RAM_WIDTH8;
            wstrobe_reg        <= 1'b0;
            rstrobe_reg        <= 1'b0;
            dequ_reg           <= 1'b0;
            err_flag_reg       <= 1'b0;
            timeout_reg        <= 1'b0;
            pass_cnt_reg       <= '0;
            err_cnt_reg        <= '0;
            first_err_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (enable) state_reg <= GEN;
                GEN: begin
                    addr_reg     <= lfsr_q[27:0] & ADDR_MASK;
                    d_to_ram_reg <= {~lfsr_q, lfsr_q};
                    state_reg    <= WRITE;
                end
                WRITE: if (mem_ready) begin
                    wstrobe_reg <= 1'b1;
                    width_reg   <= RAM_WIDTH64;
                    tcnt_reg    <= '0;
                    state_reg   <= WWAIT;
                end
                WWAIT: begin
                    wstrobe_reg <= 1'b0;
                    // Completion is tested first so it beats a coincident expiry.
                    if (mem_transaction_complete) begin
                        state_reg <= READ;
                    end else if (tcnt_reg == TCNT_LAST) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= HALT;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
                end
                READ: if (mem_ready) begin
                    rstrobe_reg <= 1'b1;
                    width_reg   <= READ_WIDTH;
                    tcnt_reg    <= '0;
                    state_reg   <= RWAIT;
                end
                RWAIT: begin
                    rstrobe_reg <= 1'b0;
                    if (mem_transaction_complete) begin
                        dequ_reg <= data_match;
                        if (data_match) begin
                            pass_cnt_reg <= pass_cnt_reg + 32'd1;
                        end else begin
                            err_flag_reg <= 1'b1;
                            if (err_cnt_reg == 16'd0) first_err_addr_reg <= addr_reg;
                            if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
                        end
                        state_reg <= enable ? GEN : IDLE;
                    end else if (tcnt_reg == TCNT_LAST) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= HALT;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
                end
                HALT: if (clear) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            // Placed last so a clear overrides any same-cycle statistics update.
            if (clear) begin
                pass_cnt_reg       <= '0;
                err_cnt_reg        <= '0;
                first_err_addr_reg <= '0;
                err_flag_reg       <= 1'b0;
                timeout_reg        <= 1'b0;
                dequ_reg           <= 1'b0;
            end
        end
    end

    assign mem_addr              = addr_reg;
    assign mem_d_to_ram          = d_to_ram_reg;
    assign mem_transaction_width = width_reg;
    assign mem_wstrobe           = wstrobe_reg;
    assign mem_rstrobe           = rstrobe_reg;
    assign dequ                  = dequ_reg;
    assign err_flag              = err_flag_reg;
    assign timeout               = timeout_reg;
    assign pass_cnt              = pass_cnt_reg;
    assign err_cnt               = err_cnt_reg;
    assign first_err_addr        = first_err_addr_reg;
    assign busy                  = (state_reg != IDLE) && (state_reg != HALT);

endmodule

// File: tb/tb_mem_traffic_checker.sv
// Randomized bench for mem_traffic_checker: behavioural memory plus a scoreboard
// of expected addresses, data and statistics.
module tb_mem_traffic_checker;

    localparam logic [31:0] SEED = 32'h0;
    localparam logic [27:0] MASK = 28'hFFFFFFF;
    localparam int          TMO  = 16;
`ifdef MEMTEST_FULL_COMPARE_EN
    localparam bit         FULL = 1'b1;
    localparam logic [1:0] RD_W = 2'd3;
`else
    localparam bit         FULL = 1'b0;
    localparam logic [1:0] RD_W = 2'd1;
`endif

    logic        clk_cpu = 1'b0;
    logic        rst_n, enable, clear, mem_ready, mem_transaction_complete;
    logic [63:0] mem_d_from_ram;
    logic [27:0] mem_addr, first_err_addr;
    logic [63:0] mem_d_to_ram;
    logic [1:0]  mem_transaction_width;
    logic        mem_wstrobe, mem_rstrobe, dequ, err_flag, timeout, busy;
    logic [31:0] pass_cnt;
    logic [15:0] err_cnt;

    mem_traffic_checker #(.LFSR_SEED(SEED), .ADDR_MASK(MASK), .TIMEOUT_CYC(TMO)) dut (
        .clk_cpu                  (clk_cpu),
        .rst_n                    (rst_n),
        .enable                   (enable),
        .clear                    (clear),
        .mem_ready                (mem_ready),
        .mem_transaction_complete (mem_transaction_complete),
        .mem_d_from_ram           (mem_d_from_ram),
        .mem_addr                 (mem_addr),
        .mem_d_to_ram             (mem_d_to_ram),
        .mem_transaction_width    (mem_transaction_width),
        .mem_wstrobe              (mem_wstrobe),
        .mem_rstrobe              (mem_rstrobe),
        .dequ                     (dequ),
        .err_flag                 (err_flag),
        .timeout                  (timeout),
        .pass_cnt                 (pass_cnt),
        .err_cnt                  (err_cnt),
        .first_err_addr           (first_err_addr),
        .busy                     (busy)
    );

    always #5 clk_cpu = ~clk_cpu;

    int          checks = 0;
    int          errors = 0;
    int          iter_no = 0;
    logic [31:0] mx;
    logic [31:0] exp_pass;
    logic [15:0] exp_err;
    logic        exp_flag, exp_dequ;
    logic [27:0] exp_first;
    logic [63:0] mem [logic [27:0]];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = SEED; exp_pass = 0; exp_err = 0; exp_flag = 0; exp_dequ = 0; exp_first = 0;
    endtask

    task automatic model_clear();
        exp_pass = 0; exp_err = 0; exp_flag = 0; exp_dequ = 0; exp_first = 0;
    endtask

    // Next expected pattern, straight from the generator rule.
    task automatic model_next(output logic [27:0] a, output logic [63:0] d);
        a  = mx[27:0] & MASK;
        d  = {~mx, mx};
        mx = {mx[30:0], ~(mx[31] ^ mx[21] ^ mx[1] ^ mx[0])};
    endtask

    task automatic wait_strobe(input bit is_write, input bit rand_ready, output int cycles, output bit ok);
        cycles = 0; ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_cpu);
            mem_transaction_complete = 1'b0;
            cycles++;
            if ((is_write ? mem_wstrobe : mem_rstrobe) === 1'b1) begin
                ok = 1;
                break;
            end
            mem_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            // Stray completions here land outside the wait states and must be ignored.
            if (rand_ready && $urandom_range(0, 3) == 0) mem_transaction_complete = 1'b1;
        end
        if (!ok) begin
            if (is_write) check_val("wstrobe_wait", 0, 1);
            else          check_val("rstrobe_wait", 0, 1);
        end
    endtask

    task automatic complete_after(input int d, input bit clr);
        repeat (d) @(negedge clk_cpu);
        mem_transaction_complete = 1'b1;
        clear = clr;
        @(negedge clk_cpu);
        mem_transaction_complete = 1'b0;
        clear = 1'b0;
    endtask

    task automatic run_iter(input int flip, input int wd, input int rd, input bit clr,
                            input bit rand_ready, input bit drop_en, output int wcyc);
        logic [27:0] ea;
        logic [63:0] ed;
        int          rcyc;
        bit          ok, mis;
        iter_no++;
        model_next(ea, ed);
        wait_strobe(1, rand_ready, wcyc, ok);
        if (!ok) return;
        check_val("waddr", mem_addr, ea);
        check_val("wdata", mem_d_to_ram, ed);
        check_val("wwidth", mem_transaction_width, 2'd3);
        mem[mem_addr] = mem_d_to_ram;
        if (drop_en) enable = 1'b0;
        complete_after(wd, 1'b0);
        wait_strobe(0, rand_ready, rcyc, ok);
        if (!ok) return;
        check_val("raddr", mem_addr, ea);
        check_val("rwidth", mem_transaction_width, RD_W);
        mem_d_from_ram = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
        if (flip >= 0) mem_d_from_ram[flip] = ~mem_d_from_ram[flip];
        mis = (flip >= 0) && (FULL || flip >= 48);
        complete_after(rd, clr);
        mem_d_from_ram = {$urandom, $urandom};
        if (clr) begin
            model_clear();
        end else begin
            exp_dequ = !mis;
            if (!mis) exp_pass++;
            else begin
                exp_flag = 1;
                if (exp_err == 0) exp_first = ea;
                if (exp_err != 16'hFFFF) exp_err++;
            end
        end
        check_val("dequ", dequ, exp_dequ);
        check_val("pass_cnt", pass_cnt, exp_pass);
        check_val("err_cnt", err_cnt, exp_err);
        check_val("err_flag", err_flag, exp_flag);
        check_val("first_err_addr", first_err_addr, exp_first);
        $display("iter %0d addr %h flip %0d wd %0d rd %0d clr %0d -> dequ %0d pass %0d err %0d",
                 iter_no, ea, flip, wd, rd, clr, dequ, pass_cnt, err_cnt);
    endtask

    initial begin
        int  wcyc, cnt, flip, wd, rd;
        bit  ok;
        logic [27:0] ea;
        logic [63:0] ed;
        rst_n = 0; enable = 0; clear = 0; mem_ready = 0;
        mem_transaction_complete = 0; mem_d_from_ram = '0;
        model_reset();
        repeat (3) @(negedge clk_cpu);
        check_val("rst_wstrobe", mem_wstrobe, 0);
        check_val("rst_rstrobe", mem_rstrobe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_data", mem_d_to_ram, 0);
        check_val("rst_pass", pass_cnt, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_flags", {dequ, err_flag, err_cnt, first_err_addr, mem_transaction_width}, 0);
        rst_n = 1;
        @(negedge clk_cpu);

        // Deterministic start: ready held high, fixed 5-cycle completions.
        enable = 1; mem_ready = 1;
        run_iter(-1, 5, 5, 0, 0, 0, wcyc);
        check_val("wstrobe_latency", wcyc, 3);
        run_iter(-1, 5, 5, 0, 0, 0, wcyc);
        run_iter(50, 5, 5, 0, 0, 0, wcyc);
        run_iter(-1, 5, 5, 0, 0, 0, wcyc);
        run_iter(3, 5, 5, 0, 0, 0, wcyc);
        // Completion exactly on the last allowed wait cycle must still win.
        run_iter(-1, TMO - 1, TMO - 1, 0, 1, 0, wcyc);
        check_val("late_complete_timeout", timeout, 0);

        for (int i = 0; i < 40; i++) begin
            flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : -1;
            wd = ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 6));
            rd = ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 6));
            run_iter(flip, wd, rd, 0, 1, 0, wcyc);
        end

        // Clear coinciding with a read completion, then a clean 100-iteration run.
        run_iter(-1, 2, 2, 1, 1, 0, wcyc);
        for (int i = 0; i < 100; i++) begin
            run_iter(-1, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 0, 1, 0, wcyc);
        end
        check_val("clean_run_pass", pass_cnt, 100);

        // Enable dropped during WWAIT: iteration completes, then idles.
        run_iter(-1, 4, 4, 0, 1, 1, wcyc);
        check_val("drop_busy", busy, 0);
        cnt = 0;
        mem_ready = 1;
        for (int i = 0; i < 12; i++) begin
            mem_transaction_complete = (i % 3 == 0);
            @(negedge clk_cpu);
            if (mem_wstrobe || mem_rstrobe || busy) cnt++;
        end
        mem_transaction_complete = 0;
        check_val("idle_activity", cnt, 0);
        check_val("idle_pass", pass_cnt, exp_pass);

        // Timeout: write never completes.
        enable = 1;
        model_next(ea, ed);
        wait_strobe(1, 0, wcyc, ok);
        check_val("tmo_waddr", mem_addr, ea);
        repeat (TMO - 1) @(negedge clk_cpu);
        check_val("tmo_early", timeout, 0);
        check_val("tmo_early_busy", busy, 1);
        @(negedge clk_cpu);
        check_val("tmo_set", timeout, 1);
        check_val("tmo_busy", busy, 0);
        repeat (4) @(negedge clk_cpu);
        check_val("halt_stays", {busy, timeout, mem_wstrobe}, 3'b010);
        enable = 0; clear = 1;
        @(negedge clk_cpu);
        clear = 0;
        model_clear();
        check_val("clr_timeout", timeout, 0);
        check_val("clr_pass", pass_cnt, 0);
        @(negedge clk_cpu);
        check_val("clr_idle_busy", busy, 0);

        // Leaves HALT: a new iteration runs with the following pattern.
        enable = 1;
        run_iter(-1, 3, 3, 0, 1, 0, wcyc);

        // Async reset while the read strobe is high.
        model_next(ea, ed);
        wait_strobe(1, 0, wcyc, ok);
        complete_after(2, 0);
        wait_strobe(0, 0, wcyc, ok);
        check_val("pre_rst_rstrobe", mem_rstrobe, 1);
        rst_n = 0;
        #1;
        check_val("arst_rstrobe", mem_rstrobe, 0);
        check_val("arst_outputs", {mem_addr, mem_d_to_ram, busy, pass_cnt, dequ}, 0);
        model_reset();
        @(negedge clk_cpu);
        rst_n = 1;
        run_iter(-1, 5, 5, 0, 0, 0, wcyc);
        run_iter(-1, 5, 5, 0, 1, 0, wcyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
